// File: rtl/bscan_tap_ctrl.sv
// Boundary-scan TAP controller: 16-state TAP FSM, instruction register, bypass and BSR.
// Optional macro BSCAN_IDCODE_EN adds a 32-bit ID register and makes IDCODE the reset instruction.
module bscan_tap_ctrl #(
    parameter int          N_IN       = 2,
    parameter int          N_OUT      = 2,
    parameter int          IR_W       = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic             tck,
    input  logic             rst,
    input  logic             tms,
    input  logic             tdi,
    output logic             tdo,
    output logic             tdo_en,
    input  logic [N_IN-1:0]  sys_in,
    output logic [N_IN-1:0]  core_in,
    input  logic [N_OUT-1:0] core_out,
    output logic [N_OUT-1:0] sys_out,
    output logic [IR_W-1:0]  ir_q,
    output logic [3:0]       tap_state
);
    localparam int L = N_IN + N_OUT;

    localparam logic [IR_W-1:0] OP_EXTEST = '0;
    localparam logic [IR_W-1:0] OP_SAMPLE = IR_W'(2);
    localparam logic [IR_W-1:0] OP_INTEST = IR_W'(4);
    localparam logic [IR_W-1:0] OP_BYPASS = '1;
    localparam logic [IR_W-1:0] OP_IDCODE = OP_BYPASS - 1'b1;

`ifdef BSCAN_IDCODE_EN
    localparam logic [IR_W-1:0] IR_RST = OP_IDCODE;
`else
    localparam logic [IR_W-1:0] IR_RST = OP_BYPASS;
`endif

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR,
        UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } state_t;

    state_t          state, state_nxt;
    logic [L-1:0]    bsr_sh, bsr_upd;
    logic [IR_W-1:0] ir_sh;
    logic            byp;
    logic            bsr_sel, id_sel, id_bit, dr_bit;
    logic            extest, intest;

    assign extest  = (ir_q == OP_EXTEST);
    assign intest  = (ir_q == OP_INTEST);
    assign bsr_sel = extest || intest || (ir_q == OP_SAMPLE);

`ifdef BSCAN_IDCODE_EN
    logic [31:0] id_sh;
    assign id_sel = (ir_q == OP_IDCODE);
    assign id_bit = id_sh[0];

    always_ff @(posedge tck) begin
        if (rst)
            id_sh <= '0;
        else if (id_sel && state == CAP_DR)
            id_sh <= IDCODE_VAL;
        else if (id_sel && state == SH_DR)
            id_sh <= {tdi, id_sh[31:1]};
    end
`else
    logic unused_idcode;
    assign unused_idcode = ^IDCODE_VAL;
    assign id_sel        = 1'b0;
    assign id_bit        = 1'b0;
`endif

    // Unknown opcodes fall through to bypass.
    assign dr_bit = bsr_sel ? bsr_sh[0] : (id_sel ? id_bit : byp);

    always_ff @(posedge tck) begin
        if (rst) state <= TLR;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tdo       = 1'b0;
        tdo_en    = 1'b0;
        case (state)
            TLR:    state_nxt = tms ? TLR    : RTI;
            RTI:    state_nxt = tms ? SEL_DR : RTI;
            SEL_DR: state_nxt = tms ? SEL_IR : CAP_DR;
            CAP_DR: state_nxt = tms ? EX1_DR : SH_DR;
            SH_DR: begin
                state_nxt = tms ? EX1_DR : SH_DR;
                tdo       = dr_bit;
                tdo_en    = 1'b1;
            end
            EX1_DR: state_nxt = tms ? UPD_DR : PAU_DR;
            PAU_DR: state_nxt = tms ? EX2_DR : PAU_DR;
            EX2_DR: state_nxt = tms ? UPD_DR : SH_DR;
            UPD_DR: state_nxt = tms ? SEL_DR : RTI;
            SEL_IR: state_nxt = tms ? TLR    : CAP_IR;
            CAP_IR: state_nxt = tms ? EX1_IR : SH_IR;
            SH_IR: begin
                state_nxt = tms ? EX1_IR : SH_IR;
                tdo       = ir_sh[0];
                tdo_en    = 1'b1;
            end
            EX1_IR: state_nxt = tms ? UPD_IR : PAU_IR;
            PAU_IR: state_nxt = tms ? EX2_IR : PAU_IR;
            EX2_IR: state_nxt = tms ? UPD_IR : SH_IR;
            UPD_IR: state_nxt = tms ? SEL_DR : RTI;
            default: state_nxt = TLR;
        endcase
    end

    always_ff @(posedge tck) begin
        if (rst) begin
            bsr_sh  <= '0;
            bsr_upd <= '0;
            byp     <= 1'b0;
            ir_sh   <= '0;
            ir_q    <= IR_RST;
        end else begin
            case (state)
                CAP_DR: begin
                    if (bsr_sel) bsr_sh <= {core_out, sys_in};
                    byp <= 1'b0;
                end
                SH_DR: begin
                    if (bsr_sel)      bsr_sh <= {tdi, bsr_sh[L-1:1]};
                    else if (!id_sel) byp    <= tdi;
                end
                UPD_DR: if (bsr_sel) bsr_upd <= bsr_sh;
                CAP_IR: ir_sh <= IR_W'(2'b01);
                SH_IR:  ir_sh <= {tdi, ir_sh[IR_W-1:1]};
                UPD_IR: ir_q  <= ir_sh;
                default: ;
            endcase
            // Falling into TLR via tms restores the reset instruction; BSR update stage is kept.
            if (state_nxt == TLR) ir_q <= IR_RST;
        end
    end

    assign core_in   = intest ? bsr_upd[N_IN-1:0] : sys_in;
    assign sys_out   = (extest || intest) ? bsr_upd[L-1:N_IN] : core_out;
    assign tap_state = state;

endmodule

// File: tb/tb_bscan_tap_ctrl.sv
// Bench for bscan_tap_ctrl: queue-based scan model checked every cycle plus directed literal checks.
module tb_bscan_tap_ctrl;
    localparam int          N_IN  = 2;
    localparam int          N_OUT = 2;
    localparam int          IR_W  = 4;
    localparam logic [31:0] IDV   = 32'h1000_0001;
`ifdef BSCAN_IDCODE_EN
    localparam logic [3:0] IR_RST = 4'hE;
`else
    localparam logic [3:0] IR_RST = 4'hF;
`endif

    logic             tck = 1'b0, rst, tms, tdi, tdo, tdo_en;
    logic [N_IN-1:0]  sys_in, core_in;
    logic [N_OUT-1:0] core_out, sys_out;
    logic [IR_W-1:0]  ir_q;
    logic [3:0]       tap_state;

    bscan_tap_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .IR_W(IR_W), .IDCODE_VAL(IDV)) dut (
        .tck(tck), .rst(rst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
        .sys_in(sys_in), .core_in(core_in), .core_out(core_out), .sys_out(sys_out),
        .ir_q(ir_q), .tap_state(tap_state)
    );

    always #5 tck = ~tck;

    int n_chk = 0, n_fail = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
    int       m_st = 0;
    logic [3:0] m_ir = IR_RST, m_upd = '0;
    bit drq[$];
    bit irq[$];

    // 0 EXTEST, 1 SAMPLE, 2 INTEST, 3 IDCODE, 4 BYPASS
    function automatic int kind(input logic [3:0] ir);
        if (ir == 4'h0) return 0;
        if (ir == 4'h2) return 1;
        if (ir == 4'h4) return 2;
`ifdef BSCAN_IDCODE_EN
        if (ir == 4'hE) return 3;
`endif
        return 4;
    endfunction

    always @(posedge tck) begin
        if (rst) begin
            m_st = 0; m_ir = IR_RST; m_upd = '0;
        end else begin
            case (m_st)
                3: begin
                    drq.delete();
                    if (kind(m_ir) <= 2) begin
                        for (int i = 0; i < N_IN; i++)  drq.push_back(sys_in[i]);
                        for (int i = 0; i < N_OUT; i++) drq.push_back(core_out[i]);
                    end else if (kind(m_ir) == 3) begin
                        for (int i = 0; i < 32; i++) drq.push_back(IDV[i]);
                    end else drq.push_back(1'b0);
                end
                4: if (drq.size() > 0) begin void'(drq.pop_front()); drq.push_back(tdi); end
                8: if (kind(m_ir) <= 2) for (int i = 0; i < 4; i++) m_upd[i] = drq[i];
                10: begin
                    irq.delete(); irq.push_back(1'b1);
                    for (int i = 1; i < IR_W; i++) irq.push_back(1'b0);
                end
                11: begin void'(irq.pop_front()); irq.push_back(tdi); end
                15: for (int i = 0; i < IR_W; i++) m_ir[i] = irq[i];
                default: ;
            endcase
            m_st = tms ? nxt1[m_st] : nxt0[m_st];
            if (m_st == 0) m_ir = IR_RST;
        end
    end

    always @(negedge tck) if (chk_en) begin
        logic e_tdo;
        e_tdo = (m_st == 4 && drq.size() > 0) ? drq[0] : (m_st == 11) ? irq[0] : 1'b0;
        chk("tap_state", tap_state, m_st);
        chk("tdo_en", tdo_en, (m_st == 4 || m_st == 11));
        chk("tdo", tdo, e_tdo);
        chk("ir_q", ir_q, m_ir);
        chk("core_in", core_in, kind(m_ir) == 2 ? m_upd[1:0] : sys_in);
        chk("sys_out", sys_out, kind(m_ir) <= 2 && kind(m_ir) != 1 ? m_upd[3:2] : core_out);
    end

    // ---------------- stimulus ----------------
    task automatic tick(input logic t, input logic d);
        tms = t; tdi = d;
        @(posedge tck); #2;
    endtask

    task automatic shift_ir(input logic [3:0] val, output logic [3:0] out);
        tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        for (int i = 0; i < IR_W; i++) begin
            out[i] = tdo;
            tick(i == IR_W - 1, val[i]);
        end
        tick(1, 0); tick(0, 0);
    endtask

    task automatic shift_dr(input int n, input logic [31:0] data, input int pause_at,
                            output logic [31:0] out);
        out = '0;
        tick(1, 0); tick(0, 0); tick(0, 0);
        for (int i = 0; i < n; i++) begin
            out[i] = tdo;
            if (i == pause_at && i != n - 1) begin
                tick(1, data[i]); tick(0, 0); tick(0, 0); tick(1, 0); tick(0, 0);
            end else tick(i == n - 1, data[i]);
        end
        tick(1, 0); tick(0, 0);
    endtask

    logic [3:0]  ir_out;
    logic [31:0] dr_out;
    logic [7:0]  path[5] = '{8'h00, 8'h01, 8'h05, 8'h03, 8'h2B};
    int          plen[5] = '{0, 3, 4, 4, 6};

    initial begin
        rst = 1; tms = 1; tdi = 0; sys_in = 2'b01; core_out = 2'b10;
        @(posedge tck); #2;
        rst = 0; chk_en = 1;
        tick(0, 0);
        chk("rst_rti", tap_state, 4'd1);
        chk("rst_ir", ir_q, IR_RST);
        chk("rst_tdo_en", tdo_en, 1'b0);
        chk("rst_tdo", tdo, 1'b0);

`ifdef BSCAN_IDCODE_EN
        shift_dr(32, 32'h0, -1, dr_out);
        chk("idcode_scan", dr_out, IDV);
`else
        shift_dr(4, 32'hB, -1, dr_out);
        chk("reset_bypass_scan", dr_out, 32'h6);
`endif

        shift_ir(4'h2, ir_out);
        chk("ir_capture", ir_out, 4'b0001);
        chk("ir_sample", ir_q, 4'h2);
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < plen[p]; i++) tick(path[p][i], 0);
            for (int i = 0; i < 5; i++) tick(1, 0);
            chk("tms_tlr", tap_state, 4'd0);
            tick(0, 0);
        end
        chk("tlr_ir_reload", ir_q, IR_RST);

        // EXTEST with a pause/resume mid-scan
        shift_ir(4'h0, ir_out);
        shift_dr(4, 32'hA, 1, dr_out);
        chk("extest_capture", dr_out, 32'h9);
        chk("extest_sys_out", sys_out, 2'b10);
        chk("extest_core_in", core_in, 2'b01);

        // INTEST
        shift_ir(4'h4, ir_out);
        shift_dr(4, 32'h7, -1, dr_out);
        chk("intest_core_in", core_in, 2'b11);
        chk("intest_sys_out", sys_out, 2'b01);
        shift_dr(4, 32'h7, -1, dr_out);
        chk("intest_capture_hi", dr_out[3:2], 2'b10);

        // BYPASS
        sys_in = 2'b10; core_out = 2'b01;
        shift_ir(4'hF, ir_out);
        shift_dr(9, 32'h0A5, -1, dr_out);
        chk("bypass_stream", dr_out, 32'h14A);
        chk("bypass_core_in", core_in, 2'b10);
        chk("bypass_sys_out", sys_out, 2'b01);

        // reset in the middle of an EXTEST shift
        sys_in = 2'b01; core_out = 2'b00;
        shift_ir(4'h0, ir_out);
        shift_dr(4, 32'hC, -1, dr_out);
        chk("pre_rst_sys_out", sys_out, 2'b11);
        core_out = 2'b01;
        tick(1, 0); tick(0, 0); tick(0, 0); tick(0, 1); tick(0, 1);
        rst = 1; tick(0, 0); rst = 0;
        chk("midrst_state", tap_state, 4'd0);
        chk("midrst_sys_out", sys_out, 2'b01);
        chk("midrst_tdo_en", tdo_en, 1'b0);
        tick(0, 0);
        shift_ir(4'h0, ir_out);
        chk("midrst_upd_cleared", sys_out, 2'b00);
        chk("midrst_core_in", core_in, 2'b01);

        tick(0, 0);
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bscan_tap_ctrl.md
Name: bscan_tap_ctrl

Overview:
- Parametrised boundary-scan test controller: full 16-state TAP FSM, instruction register, bypass register, and a boundary-scan register (BSR) of N_IN input cells plus N_OUT output cells.
- Replaces the fixed two-chip extest/intest sequencer with a TMS-driven, instruction-decoded block.
- Instances are daisy-chained tdo→tdi at top level to build scan chains of any length.

Parameters:
- N_IN, 2, number of input boundary cells (≥1)
- N_OUT, 2, number of output boundary cells (≥1)
- IR_W, 4, instruction register width (≥2)
- IDCODE_VAL, 32'h1000_0001, device ID (used only with IDCODE_EN)

Ports:
- tck  input  1  test clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- tms  input  1  test mode select, sampled on rising tck
- tdi  input  1  serial data in
- tdo  output  1  serial data out
- tdo_en  output  1  high while in Shift-DR or Shift-IR
- sys_in  input  N_IN  values from device input pins
- core_in  output  N_IN  values delivered to core logic
- core_out  input  N_OUT  values produced by core logic
- sys_out  output  N_OUT  values driven to device output pins
- ir_q  output  IR_W  current (updated) instruction
- tap_state  output  4  current TAP state encoding, for debug

Behaviour:
- Reset: rst=1 at a rising edge has the following effects.
  - FSM goes to TEST_LOGIC_RESET (0).
  - ir_q = IDCODE (with IDCODE_EN) or BYPASS (all ones).
  - BSR shift and update stages cleared to 0; bypass reg = 0.
  - tdo=0, tdo_en=0.
  - rst mid-shift aborts with no update.
- TAP encoding: TLR 0, RTI 1, SEL_DR 2, CAP_DR 3, SH_DR 4, EX1_DR 5, PAU_DR 6, EX2_DR 7, UPD_DR 8, SEL_IR 9, CAP_IR 10, SH_IR 11, EX1_IR 12, PAU_IR 13, EX2_IR 14, UPD_IR 15.
- Transitions follow IEEE 1149.1 exactly. Five consecutive tms=1 reach TLR from any state.
- Entering TLR by tms (not rst) also reloads ir_q to its reset value. The BSR update stage is retained.
- Instruction decode: EXTEST = 0, SAMPLE = 2, INTEST = 4, IDCODE = {IR_W{1'b1}}-1, BYPASS = all ones. Any other code is treated as BYPASS.
- Data register select:
  - EXTEST, SAMPLE, INTEST select the BSR (length L = N_IN + N_OUT).
  - BYPASS selects the 1-bit bypass reg.
  - IDCODE selects the 32-bit ID reg.
- BSR layout:
  - bits [N_IN-1:0] are input cells; bits [L-1:N_IN] are output cells.
  - Shift moves tdi into bit L-1 and shifts right; tdo = bit 0.
- CAP_DR (one tck):
  - input cells load sys_in; output cells load core_out.
  - bypass loads 0; ID reg loads IDCODE_VAL.
- SH_DR: one bit per tck in the selected register. tdo is combinational from the selected register's bit 0.
- UPD_DR: BSR update stage loads the shift stage. Only in EXTEST, SAMPLE or INTEST; in other instructions no change.
- CAP_IR: IR shift stage loads {IR_W-2 zeros, 2'b01}.
- SH_IR: shifts tdi into MSB; tdo = LSB.
- UPD_IR: ir_q loads the shift stage, taking effect from the next cycle.
- Pin muxing:
  - EXTEST: sys_out = update[L-1:N_IN]; core_in = sys_in.
  - INTEST: core_in = update[N_IN-1:0]; sys_out = update[L-1:N_IN].
  - All others: core_in = sys_in, sys_out = core_out (transparent).
- tdo outside shift states = 0.
- Pause states hold all registers. An Exit2 → Shift resume continues without losing bits.
- Latency: from UPD_DR/UPD_IR to pin effect is 1 tck.

Optional Feature:
- Macro: BSCAN_IDCODE_EN.
- Defined: the 32-bit ID register and IDCODE instruction exist; reset/TLR instruction = IDCODE.
  - Scanning 32 DR bits right after reset returns IDCODE_VAL LSB first.
- Undefined: no ID register; the IDCODE opcode decodes as BYPASS.
  - Reset/TLR instruction = BYPASS.
  - A DR scan after reset returns 0 then delayed tdi.

Test Plan:
- rst=1 one cycle, then tms=0 for 1 tck: tap_state=1 (RTI), ir_q=4'hE (IDCODE_EN) or 4'hF, tdo_en=0.
- From RTI with tms sequence 1,1,1,1,1 from any of five random states: tap_state=0 each time.
- Shift IR=4'h0 (EXTEST), scan DR with L=4 bits 4'b1010 (LSB first 0,1,0,1), then UPD_DR:
  - sys_out=2'b10 one tck after UPD_DR.
  - tdo during the shift returns the captured {core_out, sys_in}.
- INTEST with BSR update=4'b0111: core_in=2'b11, sys_out=2'b01; after CAP_DR with core_out=2'b10, shifted-out bits [3:2]=2'b10.
- BYPASS: shift 8 bits 8'hA5 through DR: tdo sequence is 0 followed by 8'hA5 delayed by one tck; pins transparent throughout.
- Mid-shift assert rst during SH_DR in EXTEST: tap_state=0, sys_out follows core_out next cycle, BSR update stage=0.
